// File: rtl/wb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : wb_trace_buffer
//  Purpose  : Snoops register-file writebacks into a timestamped show-ahead
//             FIFO; drops and counts entries when full.
//  Revision : 1.0  initial release
// ============================================================================
module wb_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_en,
    input  logic [4:0]               wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     capture_en,
    input  logic                     clear,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [4:0]               rd_reg,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL    = CW'(DEPTH);
    localparam logic [15:0]   C_DROPMAX = 16'hFFFF;

    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [4:0]        reg_mem_q  [DEPTH];
    logic [TS_W-1:0]   ts_mem_q   [DEPTH];

    logic w_push, w_pop, w_full, w_empty, w_push_ok, w_drop, w_wr_en;

    assign w_full    = (count_q == C_FULL);
    assign w_empty   = (count_q == '0);
    assign w_push    = wb_en & capture_en & (wb_rd != 5'd0);
    assign w_pop     = ~w_empty & rd_ready;
    // A full FIFO can still accept a push when a pop frees the head slot.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_wr_en   = w_push_ok & ~clear;

    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            count_d = count_q + CW'(w_push_ok) - CW'(w_pop);
            if (w_push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            if (w_drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != C_DROPMAX) drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            data_mem_q[wr_ptr_q] <= wb_data;
            reg_mem_q[wr_ptr_q]  <= wb_rd;
            ts_mem_q[wr_ptr_q]   <= ts_q;
        end
    end

    assign rd_valid = ~w_empty;
    assign rd_data  = rd_valid ? data_mem_q[rd_ptr_q] : '0;
    assign rd_reg   = rd_valid ? reg_mem_q[rd_ptr_q]  : '0;
    assign rd_ts    = rd_valid ? ts_mem_q[rd_ptr_q]   : '0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_trace_buffer
//  Purpose  : Directed and randomized checks of wb_trace_buffer against a
//             queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_trace_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wb_en = 1'b0;
    logic [4:0]        wb_rd = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              capture_en = 1'b0;
    logic              clear = 1'b0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        rd_reg;
    logic [TS_W-1:0]   rd_ts;
    logic [4:0]        count;
    logic              overflow;
    logic [15:0]       drop_cnt;

    wb_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .capture_en(capture_en), .clear(clear), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_reg(rd_reg), .rd_ts(rd_ts),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [4:0]        r;
        logic [TS_W-1:0]   t;
    } ent_t;

    ent_t        m_q[$];
    logic [15:0] m_ts;
    logic        m_ovf;
    logic [15:0] m_drops;
    logic        m_fresh;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ts    = '0;
        m_ovf   = 1'b0;
        m_drops = '0;
        m_fresh = 1'b1;
    endtask

    task automatic compare_all();
        check_val("count",    64'(count),    64'(m_q.size()));
        check_val("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
        check_val("overflow", 64'(overflow), 64'(m_ovf));
        check_val("drop_cnt", 64'(drop_cnt), 64'(m_drops));
        if (m_q.size() != 0) begin
            check_val("rd_data", 64'(rd_data), 64'(m_q[0].d));
            check_val("rd_reg",  64'(rd_reg),  64'(m_q[0].r));
            check_val("rd_ts",   64'(rd_ts),   64'(m_q[0].t));
        end else if (m_fresh) begin
            check_val("empty_data", 64'(rd_data), 64'd0);
            check_val("empty_reg",  64'(rd_reg),  64'd0);
            check_val("empty_ts",   64'(rd_ts),   64'd0);
        end
    endtask

    // Starts and ends at a negedge; one clock of stimulus, then model update and compare.
    task automatic step(input logic en, input logic [4:0] rd, input logic [DATA_W-1:0] d,
                        input logic cap, input logic clr, input logic rdy);
        logic pop, push;
        ent_t e;
        wb_en = en; wb_rd = rd; wb_data = d; capture_en = cap; clear = clr; rd_ready = rdy;
        @(posedge clk);
        pop  = (m_q.size() != 0) && rdy;
        push = en && cap && (rd != 5'd0);
        if (clr) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_drops = '0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) begin
                    e.d = d; e.r = rd; e.t = m_ts;
                    m_q.push_back(e);
                    m_fresh = 1'b0;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                end
            end
        end
        m_ts = m_ts + 16'd1;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse taken mid-cycle; effect must be immediate.
    task automatic pulse_reset(input int cycles);
        #2 rst = 1'b0;
        #1;
        check_val("rst_valid", 64'(rd_valid), 64'd0);
        check_val("rst_count", 64'(count),    64'd0);
        model_reset();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        compare_all();
    endtask

    initial begin
        model_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        compare_all();

        // First capture after three idle cycles carries ts=3.
        idle(3);
        step(1'b1, 5'd4, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
        check_val("first_ts", 64'(rd_ts), 64'd3);
        step(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b1);

        // Ordering
        step(1'b1, 5'd8,  32'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd9,  32'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd10, 32'd3, 1'b1, 1'b0, 1'b0);
        check_val("order_count", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check_val("order_data", 64'(rd_data), 64'(i + 1));
            step(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b1);
        end
        check_val("order_empty", 64'(count), 64'd0);

        // Filter: $zero destination and capture disabled
        step(1'b1, 5'd0, 32'hDEAD, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd5, 32'hBEEF, 1'b0, 1'b0, 1'b0);
        check_val("filter_count", 64'(count), 64'd0);

        // Overflow: 20 pushes into a 16-deep FIFO
        for (int i = 0; i < 20; i++)
            step(1'b1, 5'(1 + (i % 31)), 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
        check_val("ovf_count", 64'(count),    64'd16);
        check_val("ovf_flag",  64'(overflow), 64'd1);
        check_val("ovf_drops", 64'(drop_cnt), 64'd4);

        // Full with simultaneous push and pop
        step(1'b1, 5'd31, 32'h0000_ABCD, 1'b1, 1'b0, 1'b1);
        check_val("fullpp_count", 64'(count),    64'd16);
        check_val("fullpp_drops", 64'(drop_cnt), 64'd4);
        for (int i = 0; i < 16; i++) step(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b1);

        // Capture disabled keeps stored entries readable
        step(1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd7, 32'h78, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0, 1'b1);

        // Clear with push at count=5
        for (int i = 0; i < 5; i++) step(1'b1, 5'd3, 32'h500 + 32'(i), 1'b1, 1'b0, 1'b0);
        check_val("pre_clear_count", 64'(count), 64'd5);
        step(1'b1, 5'd3, 32'h5FF, 1'b1, 1'b1, 1'b1);
        check_val("clear_count", 64'(count),    64'd0);
        check_val("clear_ovf",   64'(overflow), 64'd0);

        // Reset pulse mid-readout
        for (int i = 0; i < 6; i++) step(1'b1, 5'd12, 32'h600 + 32'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b1);
        pulse_reset(2);
        idle(2);
        step(1'b1, 5'd6, 32'h0000_0606, 1'b1, 1'b0, 1'b0);
        check_val("post_rst_ts", 64'(rd_ts), 64'd2);

        // Randomized traffic: fill-biased then drain-biased
        for (int i = 0; i < 3000; i++) begin
            logic rdy;
            if (i < 1500) rdy = ($urandom_range(0, 3) == 0);
            else          rdy = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 149) == 0, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
